// File: rtl/ccip_tx_flow_batcher_if.sv
// Ingress payload stream and CCI-P channel-1 write port of ccip_tx_flow_batcher.
// The c1 request header is carried as individual fields rather than a packed struct.
interface ccip_tx_flow_batcher_if #(
    parameter int DATA_WIDTH = 512,
    parameter int LNUM_FLOWS = 2
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic [LNUM_FLOWS-1:0] in_flow_id;
    logic                  sRx_c1TxAlmFull;
    logic                  sTx_c1_valid;
    logic [41:0]           sTx_c1_address;
    logic [3:0]            sTx_c1_req_type;
    logic [1:0]            sTx_c1_vc_sel;
    logic [1:0]            sTx_c1_cl_len;
    logic                  sTx_c1_sop;
    logic [511:0]          sTx_c1_data;
    logic                  ccip_tx_ready;

    modport master (
        input  in_valid, in_data, in_flow_id, sRx_c1TxAlmFull,
        output sTx_c1_valid, sTx_c1_address, sTx_c1_req_type, sTx_c1_vc_sel,
               sTx_c1_cl_len, sTx_c1_sop, sTx_c1_data, ccip_tx_ready
    );

    modport slave (
        output in_valid, in_data, in_flow_id, sRx_c1TxAlmFull,
        input  sTx_c1_valid, sTx_c1_address, sTx_c1_req_type, sTx_c1_vc_sel,
               sTx_c1_cl_len, sTx_c1_sop, sTx_c1_data, ccip_tx_ready
    );
endinterface

// File: rtl/ccip_tx_flow_batcher.sv
// Per-flow FIFO batcher emitting eREQ_WRLINE_I bursts on CCI-P c1 into per-flow ring slots.
// Define CCIP_TX_PARTIAL_FLUSH_EN to add per-flow age counters and timed partial-batch flushes.
module ccip_tx_flow_batcher #(
    parameter int DATA_WIDTH  = 512,
    parameter int LNUM_FLOWS  = 2,
    parameter int LFIFO_DEPTH = 3,
    parameter int TIMEOUT_W   = 16,
    parameter int DROP_CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LNUM_FLOWS-1:0] number_of_flows,
    input  logic [41:0]           tx_base_addr,
    input  logic [1:0]            l_batch_size,
    input  logic [TIMEOUT_W-1:0]  flush_timeout,
    ccip_tx_flow_batcher_if.master bus,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  busy
);
    localparam int MAX_FLOWS = 1 << LNUM_FLOWS;
    localparam int DEPTH     = 1 << LFIFO_DEPTH;
    localparam int CW        = LFIFO_DEPTH + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
`ifdef CCIP_TX_PARTIAL_FLUSH_EN
    localparam logic [1:0] ST_FLUSH = 2'd2;
`endif

    localparam logic [3:0] REQ_WRLINE_I = 4'h0;
    localparam logic [1:0] VC_VH0       = 2'h2;
    localparam logic [1:0] CL_LEN_1     = 2'b00;

    logic [DATA_WIDTH-1:0]  mem    [MAX_FLOWS][DEPTH];
    logic [LFIFO_DEPTH-1:0] wr_ptr [MAX_FLOWS];
    logic [LFIFO_DEPTH-1:0] rd_ptr [MAX_FLOWS];
    logic [CW-1:0]          count  [MAX_FLOWS];

    logic [1:0]            state;
    logic [LNUM_FLOWS-1:0] scan_ptr;
    logic [LNUM_FLOWS-1:0] cur_flow;
    logic [LNUM_FLOWS-1:0] cur_nflows;
    logic [1:0]            cur_l;
    logic [1:0]            beat;
    logic [1:0]            last_beat;
    logic [41:0]           cur_base;
    logic                  cur_single;

    logic [1:0]            live_l;
    logic [CW-1:0]         live_b;
    logic [CW-1:0]         occ;
    logic                  push_ok;
    logic                  drop;
    logic                  pop;
    logic                  burst_go;
    logic [MAX_FLOWS-1:0]  push_vec;
    logic [MAX_FLOWS-1:0]  pop_vec;
    logic [LNUM_FLOWS-1:0] scan_next;
    logic [LNUM_FLOWS-1:0] served_next;

    logic                  s1_valid;
    logic [41:0]           s1_addr;
    logic [1:0]            s1_len;
    logic                  s1_sop;
    logic [511:0]          s1_data;

    always_comb begin
        live_l      = (l_batch_size > 2'd2) ? 2'd2 : l_batch_size;
        live_b      = CW'(1) << live_l;
        occ         = count[scan_ptr];
        push_ok     = bus.in_valid && start && (bus.in_flow_id <= number_of_flows)
                      && (count[bus.in_flow_id] != CW'(DEPTH));
        drop        = bus.in_valid && start && !push_ok;
        pop         = (state != ST_IDLE);
        burst_go    = start && !bus.sRx_c1TxAlmFull && (occ >= live_b);
        scan_next   = (scan_ptr >= number_of_flows) ? '0 : scan_ptr + 1'b1;
        served_next = (cur_flow >= cur_nflows) ? '0 : cur_flow + 1'b1;
        for (int f = 0; f < MAX_FLOWS; f++) begin
            push_vec[f] = push_ok && (bus.in_flow_id == LNUM_FLOWS'(f));
            pop_vec[f]  = pop && (cur_flow == LNUM_FLOWS'(f));
        end
    end

    // A same-cycle push and pop on one flow leave its occupancy unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int f = 0; f < MAX_FLOWS; f++) begin
                wr_ptr[f] <= '0;
                rd_ptr[f] <= '0;
                count[f]  <= '0;
            end
        end else begin
            for (int f = 0; f < MAX_FLOWS; f++) begin
                if (push_vec[f]) wr_ptr[f] <= wr_ptr[f] + 1'b1;
                if (pop_vec[f])  rd_ptr[f] <= rd_ptr[f] + 1'b1;
                if (push_vec[f] && !pop_vec[f])
                    count[f] <= count[f] + 1'b1;
                else if (!push_vec[f] && pop_vec[f])
                    count[f] <= count[f] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[bus.in_flow_id][wr_ptr[bus.in_flow_id]] <= bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (reset)
            drop_cnt <= '0;
        else if (drop && (drop_cnt != {DROP_CNT_W{1'b1}}))
            drop_cnt <= drop_cnt + 1'b1;
    end

`ifdef CCIP_TX_PARTIAL_FLUSH_EN
    logic [TIMEOUT_W-1:0] age [MAX_FLOWS];
    logic                 flush_go;

    assign flush_go = start && !bus.sRx_c1TxAlmFull && (flush_timeout != '0)
                      && (age[scan_ptr] >= flush_timeout)
                      && (occ != '0) && (occ < live_b);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int f = 0; f < MAX_FLOWS; f++) age[f] <= '0;
        end else begin
            for (int f = 0; f < MAX_FLOWS; f++) begin
                if ((count[f] == '0) || pop_vec[f])
                    age[f] <= '0;
                else if (age[f] != {TIMEOUT_W{1'b1}})
                    age[f] <= age[f] + 1'b1;
            end
        end
    end
`else
    logic unused_flush;
    assign unused_flush = ^flush_timeout;
`endif

    // Burst geometry and base address are frozen on leaving IDLE; the scan resumes after the served flow.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            scan_ptr   <= '0;
            cur_flow   <= '0;
            cur_nflows <= '0;
            cur_l      <= '0;
            beat       <= '0;
            last_beat  <= '0;
            cur_base   <= '0;
            cur_single <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    beat <= '0;
                    if (burst_go) begin
                        state      <= ST_BURST;
                        cur_flow   <= scan_ptr;
                        cur_nflows <= number_of_flows;
                        cur_l      <= live_l;
                        cur_base   <= tx_base_addr;
                        last_beat  <= 2'(live_b - 1'b1);
                        cur_single <= 1'b0;
                    end
`ifdef CCIP_TX_PARTIAL_FLUSH_EN
                    else if (flush_go) begin
                        state      <= ST_FLUSH;
                        cur_flow   <= scan_ptr;
                        cur_nflows <= number_of_flows;
                        cur_l      <= live_l;
                        cur_base   <= tx_base_addr;
                        last_beat  <= 2'(occ - 1'b1);
                        cur_single <= 1'b1;
                    end
`endif
                    else if (start) begin
                        scan_ptr <= scan_next;
                    end
                end
                default: begin
                    beat <= beat + 1'b1;
                    if (beat == last_beat) begin
                        state    <= ST_IDLE;
                        scan_ptr <= served_next;
                        beat     <= '0;
                    end
                end
            endcase
        end
    end

    // Two register stages: FIFO read capture, then the c1 output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid            <= 1'b0;
            s1_addr             <= '0;
            s1_len              <= '0;
            s1_sop              <= 1'b0;
            s1_data             <= '0;
            bus.sTx_c1_valid    <= 1'b0;
            bus.sTx_c1_address  <= '0;
            bus.sTx_c1_req_type <= '0;
            bus.sTx_c1_vc_sel   <= '0;
            bus.sTx_c1_cl_len   <= '0;
            bus.sTx_c1_sop      <= 1'b0;
            bus.sTx_c1_data     <= '0;
        end else begin
            s1_valid            <= pop;
            s1_addr             <= cur_base + (42'(cur_flow) << cur_l) + 42'(beat);
            s1_len              <= cur_single ? CL_LEN_1 : {cur_l[1], (cur_l != 2'd0)};
            s1_sop              <= cur_single || (beat == 2'd0);
            s1_data             <= 512'(mem[cur_flow][rd_ptr[cur_flow]]);
            bus.sTx_c1_valid    <= s1_valid;
            bus.sTx_c1_address  <= s1_valid ? s1_addr : '0;
            bus.sTx_c1_req_type <= REQ_WRLINE_I;
            bus.sTx_c1_vc_sel   <= s1_valid ? VC_VH0 : 2'h0;
            bus.sTx_c1_cl_len   <= s1_valid ? s1_len : '0;
            bus.sTx_c1_sop      <= s1_valid && s1_sop;
            bus.sTx_c1_data     <= s1_data;
        end
    end

    assign bus.ccip_tx_ready = ~bus.sRx_c1TxAlmFull;
    assign busy              = (state != ST_IDLE);

endmodule

// File: tb/tb_ccip_tx_flow_batcher.sv
// Randomized and directed bench for ccip_tx_flow_batcher against a per-flow queue reference model.
// Directed flush case follows CCIP_TX_PARTIAL_FLUSH_EN.
module tb_ccip_tx_flow_batcher;
    localparam int DW    = 512;
    localparam int LNF   = 2;
    localparam int DEPTH = 8;
    localparam int NFL   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  number_of_flows = '0;
    logic [41:0] tx_base_addr = '0;
    logic [1:0]  l_batch_size = '0;
    logic [15:0] flush_timeout = '0;
    logic [31:0] drop_cnt;
    logic        busy;

    always #5 clk = ~clk;

    ccip_tx_flow_batcher_if #(.DATA_WIDTH(DW), .LNUM_FLOWS(LNF)) bus ();

    ccip_tx_flow_batcher #(
        .DATA_WIDTH(DW), .LNUM_FLOWS(LNF), .LFIFO_DEPTH(3), .TIMEOUT_W(16), .DROP_CNT_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .number_of_flows(number_of_flows),
        .tx_base_addr(tx_base_addr),
        .l_batch_size(l_batch_size),
        .flush_timeout(flush_timeout),
        .bus(bus),
        .drop_cnt(drop_cnt),
        .busy(busy)
    );

    typedef struct {
        logic [41:0]  addr;
        logic [3:0]   req;
        logic [1:0]   vc;
        logic [1:0]   len;
        logic         sop;
        logic [511:0] data;
        int           cyc;
    } beat_t;

    beat_t        seen[$];
    beat_t        monBeat;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    int           expDrops;
    int           acc[NFL];
    logic [511:0] accData[NFL][DEPTH];
    int           curL, curB, curNf;
    logic [41:0]  curBase;

    always @(posedge clk) cyc <= cyc + 1;

    // Every valid c1 beat is recorded with the cycle it appeared in.
    always @(negedge clk) begin
        if (!reset && bus.sTx_c1_valid) begin
            monBeat.addr = bus.sTx_c1_address;
            monBeat.req  = bus.sTx_c1_req_type;
            monBeat.vc   = bus.sTx_c1_vc_sel;
            monBeat.len  = bus.sTx_c1_cl_len;
            monBeat.sop  = bus.sTx_c1_sop;
            monBeat.data = bus.sTx_c1_data;
            monBeat.cyc  = cyc;
            seen.push_back(monBeat);
        end
    end

    task automatic checkOutput(input string tag, input logic [511:0] actual, input logic [511:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] randData();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic setup(input int l, input int nf, input logic [41:0] base, input logic [15:0] ft, input logic af);
        l_batch_size        = 2'(l);
        number_of_flows     = 2'(nf);
        tx_base_addr        = base;
        flush_timeout       = ft;
        bus.sRx_c1TxAlmFull = af;
        bus.in_valid        = 1'b0;
        bus.in_flow_id      = '0;
        bus.in_data         = '0;
        start               = 1'b1;
        curL    = (l > 2) ? 2 : l;
        curB    = 1 << curL;
        curNf   = nf;
        curBase = base;
        reset = 1'b1;
        idleCycles(2);
        checkOutput("reset_valid", bus.sTx_c1_valid, 0);
        checkOutput("reset_addr", bus.sTx_c1_address, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_drop", drop_cnt, 0);
        checkOutput("ready_follows_af", bus.ccip_tx_ready, !af);
        reset = 1'b0;
        expDrops = 0;
        for (int f = 0; f < NFL; f++) acc[f] = 0;
        seen.delete();
    endtask

    task automatic applyStimulus(input int flow, input logic [511:0] data, input logic st);
        bus.in_valid   = 1'b1;
        bus.in_flow_id = 2'(flow);
        bus.in_data    = data;
        start          = st;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        start        = 1'b1;
        if (st) begin
            if (flow > curNf || acc[flow] == DEPTH)
                expDrops++;
            else begin
                accData[flow][acc[flow]] = data;
                acc[flow]++;
            end
        end
    endtask

    task automatic waitBeats(input int n, input int maxCycles);
        for (int i = 0; i < maxCycles && seen.size() < n; i++) idleCycles(1);
    endtask

    // Each accepted flow should have floor(accepted/B)*B lines written, in push order, as contiguous bursts.
    task automatic verifyBeats();
        int          idx[NFL];
        int          lastCyc[NFL];
        int          expTotal;
        logic [1:0]  expLen;
        expTotal = 0;
        for (int f = 0; f < NFL; f++) begin
            idx[f]     = 0;
            lastCyc[f] = 0;
            expTotal  += (acc[f] / curB) * curB;
        end
        expLen = (curB == 1) ? 2'b00 : (curB == 2) ? 2'b01 : 2'b11;
        checkOutput("beat_count", seen.size(), expTotal);
        foreach (seen[i]) begin
            longint      off;
            int          f;
            int          k;
            logic [41:0] expAddr;
            off = longint'(seen[i].addr - curBase);
            if ((off >> curL) > longint'(curNf)) begin
                checkOutput("beat_flow_range", seen[i].addr, curBase);
                continue;
            end
            f = int'(off >> curL);
            if (idx[f] >= acc[f]) begin
                checkOutput("beat_extra", idx[f] + 1, acc[f]);
                continue;
            end
            k       = idx[f] % curB;
            expAddr = curBase + 42'(f << curL) + 42'(k);
            checkOutput("beat_addr", seen[i].addr, expAddr);
            checkOutput("beat_data", seen[i].data, accData[f][idx[f]]);
            checkOutput("beat_sop", seen[i].sop, (k == 0));
            checkOutput("beat_len", seen[i].len, expLen);
            checkOutput("beat_req", seen[i].req, 4'h0);
            checkOutput("beat_vc", seen[i].vc, 2'h2);
            if (k != 0) checkOutput("beat_contig", seen[i].cyc, lastCyc[f] + 1);
            lastCyc[f] = seen[i].cyc;
            idx[f]++;
        end
    endtask

    // Mode 0 buffers everything under almost-full (overflow possible); mode 1 drains while pushing.
    task automatic randomPhase(input int mode);
        int n;
        setup($urandom_range(0, 3), $urandom_range(0, 3), {10'h0, 32'($urandom)}, 16'd0, mode == 0);
        n = $urandom_range(10, 40);
        for (int i = 0; i < n; i++) begin
            int   f;
            logic st;
            f  = $urandom_range(0, 3);
            st = ($urandom_range(0, 7) != 0);
            if (mode == 1) bus.sRx_c1TxAlmFull = ($urandom_range(0, 3) == 0);
            if (mode == 1 && st && f <= curNf && acc[f] >= DEPTH)
                idleCycles(1);
            else
                applyStimulus(f, randData(), st);
            if ($urandom_range(0, 3) == 0) idleCycles(1);
        end
        bus.sRx_c1TxAlmFull = 1'b0;
        idleCycles(150);
        checkOutput("drop_cnt", drop_cnt, expDrops);
        checkOutput("busy_end", busy, 0);
        verifyBeats();
    endtask

    initial begin
        int c0;
        int n;

        // Single line, single flow.
        setup(0, 0, 42'h1000, 16'd0, 1'b0);
        applyStimulus(0, randData(), 1'b1);
        waitBeats(1, 20);
        idleCycles(5);
        verifyBeats();
        if (seen.size() > 0) checkOutput("t1_addr", seen[0].addr, 42'h1000);

        // Four-line burst on flow 2.
        setup(2, 3, 42'h1000, 16'd0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(2, randData(), 1'b1);
        idleCycles(30);
        verifyBeats();
        if (seen.size() > 0) checkOutput("t2_addr0", seen[0].addr, 42'h1008);

        // Overflow under almost-full, then two bursts.
        setup(2, 3, 42'h1000, 16'd0, 1'b1);
        for (int i = 0; i < 9; i++) applyStimulus(1, randData(), 1'b1);
        idleCycles(20);
        checkOutput("t3_drop", drop_cnt, 1);
        checkOutput("t3_nowrites", seen.size(), 0);
        bus.sRx_c1TxAlmFull = 1'b0;
        idleCycles(60);
        verifyBeats();

        // Out-of-range flow id is dropped; in-range still works.
        setup(0, 1, 42'h1000, 16'd0, 1'b0);
        applyStimulus(3, randData(), 1'b1);
        idleCycles(10);
        checkOutput("t4_drop", drop_cnt, 1);
        checkOutput("t4_nowrites", seen.size(), 0);
        applyStimulus(1, randData(), 1'b1);
        idleCycles(20);
        verifyBeats();

        // Partial batch with a timeout of 20 cycles.
        setup(2, 0, 42'h1000, 16'd20, 1'b0);
        c0 = cyc;
        for (int i = 0; i < 3; i++) applyStimulus(0, randData(), 1'b1);
`ifdef CCIP_TX_PARTIAL_FLUSH_EN
        waitBeats(3, 80);
        checkOutput("t5_count", seen.size(), 3);
        foreach (seen[i]) begin
            checkOutput("t5_addr", seen[i].addr, 42'h1000 + 42'(i));
            checkOutput("t5_sop", seen[i].sop, 1);
            checkOutput("t5_len", seen[i].len, 2'b00);
            if (i < 3) checkOutput("t5_data", seen[i].data, accData[0][i]);
        end
        if (seen.size() > 0) checkOutput("t5_delay", (seen[0].cyc - c0) >= 20, 1);
`else
        idleCycles(60);
        checkOutput("t5_held", seen.size(), 0);
        applyStimulus(0, randData(), 1'b1);
        idleCycles(20);
        verifyBeats();
`endif

        // Reset while beat 1 of a 4-beat burst is on the bus.
        setup(2, 0, 42'h1000, 16'd0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(0, randData(), 1'b1);
        bus.sRx_c1TxAlmFull = 1'b0;
        for (int i = 0; i < 30 && !bus.sTx_c1_valid; i++) idleCycles(1);
        checkOutput("t6_beat0_valid", bus.sTx_c1_valid, 1);
        checkOutput("t6_beat0_sop", bus.sTx_c1_sop, 1);
        idleCycles(1);
        checkOutput("t6_beat1_addr", bus.sTx_c1_address, 42'h1001);
        reset = 1'b1;
        idleCycles(1);
        checkOutput("t6_valid_low", bus.sTx_c1_valid, 0);
        reset = 1'b0;
        n = seen.size();
        idleCycles(30);
        checkOutput("t6_no_residual", seen.size(), n);
        checkOutput("t6_busy", busy, 0);

        for (int p = 0; p < 10; p++) randomPhase(p % 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/ccip_tx_flow_batcher.md
Name: ccip_tx_flow_batcher

Overview:
Parametrised CPU-bound transmit path: accepts RPC payloads tagged with a flow ID and buffers them in per-flow FIFOs. It emits batched eREQ_WRLINE_I writes on CCI-P channel 1 into a per-flow ring slot at tx_base_addr. Unlike the previous transmitter, it adds an optional partial-batch flush after a per-flow timeout. It sits between the RPC pipeline and the CCI-P c1 TX port.

Parameters:
DATA_WIDTH, 512, payload bits per cache line (≤512; upper line bits are zero-filled)
LNUM_FLOWS, 2, log2 of max flows (MAX_FLOWS = 2**LNUM_FLOWS)
LFIFO_DEPTH, 3, log2 of per-flow FIFO depth; must be ≥ 2
TIMEOUT_W, 16, width of the flush timeout and the per-flow age counters
DROP_CNT_W, 32, width of the drop counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  enables ingress accept and the arbiter
number_of_flows  in  LNUM_FLOWS  index of the highest active flow (active flows = value+1)
tx_base_addr  in  t_ccip_clAddr  base line address of the TX ring
l_batch_size  in  2  log2 batch: 0→1, 1→2, 2→4 lines; 3 is clamped to 2
flush_timeout  in  TIMEOUT_W  idle cycles before a partial flush; 0 disables flush
in_valid  in  1  payload valid
in_data  in  DATA_WIDTH  payload
in_flow_id  in  LNUM_FLOWS  target flow
sRx_c1TxAlmFull  in  1  CCI-P c1 almost-full
sTx_c1  out  t_if_ccip_c1_Tx  CCI-P write request
ccip_tx_ready  out  1  ~sRx_c1TxAlmFull (combinational)
drop_cnt  out  DROP_CNT_W  saturating count of dropped payloads
busy  out  1  high in BURST or FLUSH

Behaviour:
- Reset: all FIFOs empty; state IDLE; scan pointer 0; sTx_c1.valid=0 and hdr=0; drop_cnt=0; age counters 0; busy=0. A reset mid-burst aborts the burst and discards all buffered data. valid is low in the cycle after reset is sampled.
- Ingress: if in_valid && start, the payload is written into FIFO[in_flow_id] at the next edge. The payload is dropped and drop_cnt incremented (saturating at all-ones) when that FIFO is full, or when in_flow_id > number_of_flows. If in_valid is high while start=0, the payload is ignored and not counted.
- B = 1<<min(l_batch_size,2). B, number_of_flows and tx_base_addr are latched on leaving IDLE and held for the whole burst or flush.
- Arbiter, IDLE state, one flow examined per cycle:
  - If occupancy[ptr] ≥ B and sRx_c1TxAlmFull=0, go to BURST for ptr.
  - Otherwise, if the flush condition holds for ptr and sRx_c1TxAlmFull=0, go to FLUSH for ptr.
  - Otherwise ptr advances, wrapping from number_of_flows to 0.
  - On leaving BURST or FLUSH, ptr advances to the next flow (round-robin fairness).
- BURST: pops B entries on consecutive cycles. Beat k (0..B-1) appears on sTx_c1 two cycles after its pop:
  - valid=1, req_type=eREQ_WRLINE_I, vc_sel=eVC_VH0, cl_len=B-1 encoding.
  - address = base + (flow<<l) + k; sop=(k==0); data = zero-extended payload.
  - Beats are contiguous; almost-full is not re-checked mid-burst (c1 absorbs ≤ 8 lines after assertion). Return to IDLE after the last pop.
- FLUSH: pops all N entries present at entry (1 ≤ N < B), as N single-line writes with cl_len=eCL_LEN_1, sop=1, address = base + (flow<<l) + k. Return to IDLE.
- Age counter per flow:
  - Cleared when the FIFO is empty or the flow is popped.
  - Otherwise increments by 1 per cycle, saturating.
  - Flush condition: flush_timeout≠0 && age ≥ flush_timeout && 0 < occupancy < B.
- Simultaneous push and pop on the same FIFO in one cycle are both honoured; occupancy is unchanged.
- While busy, ingress to any flow continues.

Optional Feature:
CCIP_TX_PARTIAL_FLUSH_EN.
- Defined: age counters and the FLUSH state are present as described.
- Undefined: no age counters and no FLUSH state; flush_timeout is ignored; only full batches of B are ever sent. Partial data remains buffered until the batch fills.

Test Plan:
1. l_batch_size=0, number_of_flows=0, base=0x1000: one payload on flow 0 → a single write, addr 0x1000, cl_len 1, sop=1, data matches.
2. l_batch_size=2, flows=4, push 4 payloads to flow 2 → 4 contiguous valid beats at 0x1008..0x100B, cl_len 4, sop only on beat 0, data in push order.
3. Depth 8, push 9 payloads to flow 1 with almost-full held high → drop_cnt=1 and no writes; deassert → 2 bursts of 4 to 0x1004.
4. in_flow_id=3 with number_of_flows=1 → drop_cnt increments; no FIFO change.
5. CCIP_TX_PARTIAL_FLUSH_EN, l=2, flush_timeout=20, push 3 payloads to flow 0 then idle → after ≥20 cycles, 3 single-line writes at 0x1000..0x1002, each sop=1.
6. Reset asserted during beat 1 of a 4-beat burst → valid low in the next cycle; after release, busy=0 and no residual beats.
